// File: rtl/pipe_stage_skid.sv
// Two-entry skid buffer between IF and ID. The main entry drives the
// outputs; the skid entry absorbs one extra instruction so in_ready can be
// a registered signal. Flush discards everything held and incoming.
module pipe_stage_skid #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  bp_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [PC_W-1:0]   main_pc, skid_pc;
  logic [INST_W-1:0] main_inst, skid_inst;

  logic accept, take;
  logic load_main_in, load_main_skid, load_skid;

  // Handshake flags are decoded from registered state only.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  // Bubble encoding whenever nothing is held.
  assign out_pc   = (state == EMPTY) ? '0 : main_pc;
  assign out_inst = (state == EMPTY) ? NOP_INST : main_inst;

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) state <= EMPTY;
    else       state <= state_next;
  end

  // Next-state and entry-load decode; flush overrides every handshake.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && take) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (take) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            state_next     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Main and skid entry storage.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      main_pc   <= '0;
      main_inst <= NOP_INST;
      skid_pc   <= '0;
      skid_inst <= '0;
    end else begin
      if (load_main_in) begin
        main_pc   <= in_pc;
        main_inst <= in_inst;
      end else if (load_main_skid) begin
        main_pc   <= skid_pc;
        main_inst <= skid_inst;
      end
      if (load_skid) begin
        skid_pc   <= in_pc;
        skid_inst <= in_inst;
      end
    end
  end

  // Saturating count of cycles where downstream stalls a valid entry.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      bp_cnt <= '0;
    end else if (out_valid && !out_ready && (bp_cnt != '1)) begin
      bp_cnt <= bp_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scenario bench for pipe_stage_skid: a negedge scoreboard tracks every
// accepted entry and checks order/contents of every presented entry,
// while per-scenario tasks check handshakes, bubbles and bp_cnt.
module tb_pipe_stage_skid;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        nrst, in_valid, flush, out_ready;
  logic [31:0] in_pc, in_inst;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_inst;
  logic [15:0] bp_cnt;
  logic        in_ready4, out_valid4;
  logic [31:0] out_pc4, out_inst4;
  logic [3:0]  bp_cnt4;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.PC_W(32), .INST_W(32), .NOP_INST(32'h00000013), .CNT_W(16)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .bp_cnt(bp_cnt)
  );

  pipe_stage_skid #(.CNT_W(4)) dut4 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush), .out_valid(out_valid4),
    .out_ready(out_ready), .out_pc(out_pc4), .out_inst(out_inst4), .bp_cnt(bp_cnt4)
  );

  // Scoreboard: inputs are stable at negedge and are what the next rising edge samples.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!nrst || flush) begin
        q.delete();
      end else begin
        if (out_valid === 1'b1) begin
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got pc=%h inst=%h, required nothing pending", out_pc, out_inst);
          end else if (out_pc !== q[0].pc || out_inst !== q[0].inst) begin
            fails++;
            $display("FAIL sb_order: got pc=%h inst=%h, required pc=%h inst=%h",
                     out_pc, out_inst, q[0].pc, q[0].inst);
          end
          if (out_ready && q.size() > 0) void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
          ent_t e;
          e.pc   = in_pc;
          e.inst = in_inst;
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0 || out_inst !== NOP || bp_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset: got v=%b r=%b pc=%h inst=%h bp=%0d, required v=0 r=1 pc=0 inst=%h bp=0",
               out_valid, in_ready, out_pc, out_inst, bp_cnt, NOP);
    end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'h00500093; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== 32'h00500093) begin
      fails++;
      $display("FAIL single_latency: got v=%b pc=%h inst=%h, required v=1 pc=100 inst=00500093",
               out_valid, out_pc, out_inst);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== NOP) begin
      fails++;
      $display("FAIL single_drain: got v=%b pc=%h inst=%h, required v=0 pc=0 inst=%h",
               out_valid, out_pc, out_inst, NOP);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(i * 4); in_inst = 32'hA000_0000 + 32'(i);
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_%0d: got v=%b pc=%h r=%b, required v=1 pc=%h r=1",
                 i, out_valid, out_pc, in_ready, 32'(i * 4));
      end
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (out_valid !== 1'b0 || bp_cnt !== 16'h0) begin
      fails++;
      $display("FAIL stream_end: got v=%b bp=%0d, required v=0 bp=0", out_valid, bp_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h20; in_inst = 32'hB20; tick();
    in_pc = 32'h24; in_inst = 32'hB24; tick();
    in_pc = 32'h28; in_inst = 32'hB28;
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_pc !== 32'h20) begin
      fails++;
      $display("FAIL bp_full: got v=%b r=%b pc=%h, required v=1 r=0 pc=20", out_valid, in_ready, out_pc);
    end
    repeat (3) tick();
    tests++;
    if (in_ready !== 1'b0 || out_pc !== 32'h20 || bp_cnt !== 16'd4) begin
      fails++;
      $display("FAIL bp_hold: got r=%b pc=%h bp=%0d, required r=0 pc=20 bp=4", in_ready, out_pc, bp_cnt);
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (out_pc !== 32'h24 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: got pc=%h r=%b, required pc=24 r=1", out_pc, in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_pc !== 32'h28 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_last: got pc=%h v=%b, required pc=28 v=1", out_pc, out_valid);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || bp_cnt !== 16'd4 || q.size() != 0) begin
      fails++;
      $display("FAIL bp_count: got v=%b bp=%0d pending=%0d, required v=0 bp=4 pending=0",
               out_valid, bp_cnt, q.size());
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h40; in_inst = 32'hC40; tick();
    in_pc = 32'h44; in_inst = 32'hC44; tick();
    in_pc = 32'h48; in_inst = 32'hC48; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || out_inst !== NOP || out_pc !== 32'h0 || in_ready !== 1'b1 || bp_cnt !== 16'd2) begin
      fails++;
      $display("FAIL flush_full: got v=%b inst=%h pc=%h r=%b bp=%0d, required v=0 inst=%h pc=0 r=1 bp=2",
               out_valid, out_inst, out_pc, in_ready, bp_cnt, NOP);
    end
    in_valid = 1'b1; in_pc = 32'h50; in_inst = 32'hC50; tick();
    in_pc = 32'h54; in_inst = 32'hC54; flush = 1'b1; out_ready = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    repeat (2) tick();
    tests++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== NOP) begin
      fails++;
      $display("FAIL flush_one: got v=%b pc=%h inst=%h, required v=0 pc=0 inst=%h",
               out_valid, out_pc, out_inst, NOP);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h60; in_inst = 32'hD60; tick();
    in_valid = 1'b0;
    repeat (14) tick();
    tests++;
    if (bp_cnt4 !== 4'd14) begin
      fails++;
      $display("FAIL sat_pre: got bp4=%0d, required 14", bp_cnt4);
    end
    repeat (6) tick();
    tests++;
    if (bp_cnt4 !== 4'd15 || bp_cnt !== 16'd20) begin
      fails++;
      $display("FAIL sat_hold: got bp4=%0d bp16=%0d, required bp4=15 bp16=20", bp_cnt4, bp_cnt);
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (bp_cnt4 !== 4'd15 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL sat_drain: got bp4=%0d v=%b, required bp4=15 v=0", bp_cnt4, out_valid);
    end
  endtask

  task automatic test_reset_full();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h70; in_inst = 32'hE70; tick();
    in_pc = 32'h74; in_inst = 32'hE74; tick();
    nrst = 1'b0; in_pc = 32'h78; in_inst = 32'hE78; out_ready = 1'b1; tick();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0 || out_inst !== NOP || bp_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset_full: got v=%b r=%b pc=%h inst=%h bp=%0d, required v=0 r=1 pc=0 inst=%h bp=0",
               out_valid, in_ready, out_pc, out_inst, bp_cnt, NOP);
    end
    nrst = 1'b1; in_valid = 1'b0;
    repeat (2) tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_drop: got v=%b, required v=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom;
      in_inst   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    tick();
    tests++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL random_drain: got pending=%0d v=%b, required pending=0 v=0", q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturate();
    test_reset_full();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter PC_W, default 32, program-counter width.
REQ-002 SHALL have parameter INST_W, default 32, instruction width.
REQ-003 SHALL have parameter NOP_INST, default 32'h00000013 (addi x0,x0,0), bubble encoding driven on out_inst when empty.
REQ-004 SHALL have parameter CNT_W, default 16, backpressure counter width.
REQ-005 SHALL have ports: clk  input  1  clock, rising edge.
REQ-006 SHALL have ports: nrst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have ports: in_valid  input  1  upstream (IF) presents pc/inst.
REQ-008 SHALL have ports: in_ready  output  1  stage can accept; registered.
REQ-009 SHALL have ports: in_pc  input  PC_W  fetched PC.
REQ-010 SHALL have ports: in_inst  input  INST_W  fetched instruction.
REQ-011 SHALL have ports: flush  input  1  discard all held and incoming entries (branch/jump redirect).
REQ-012 SHALL have ports: out_valid  output  1  downstream (ID) entry valid; registered.
REQ-013 SHALL have ports: out_ready  input  1  downstream takes entry.
REQ-014 SHALL have ports: out_pc  output  PC_W  held PC.
REQ-015 SHALL have ports: out_inst  output  INST_W  held instruction.
REQ-016 SHALL have ports: bp_cnt  output  CNT_W  saturating count of backpressure cycles.

Function
REQ-017 SHALL hold two entries, main and skid; out_pc/out_inst always come from main.
REQ-018 SHALL define accept = in_valid & in_ready and take = out_valid & out_ready, both sampled at the rising clk edge.
REQ-019 SHALL implement states EMPTY, ONE, FULL; out_valid = (state != EMPTY), in_ready = (state != FULL), both decoded from registered state.
REQ-020 SHALL transition EMPTY: accept -> ONE, main <= in.
REQ-021 SHALL transition ONE: accept & take -> ONE, main <= in; accept & !take -> FULL, skid <= in; !accept & take -> EMPTY; neither -> hold.
REQ-022 SHALL transition FULL: take -> ONE, main <= skid; no take -> hold. in_valid SHALL be ignored, since in_ready = 0.
REQ-023 SHALL give flush priority over every other event: next state EMPTY, and any entry accepted in the same cycle is discarded.
REQ-024 SHALL drive out_inst = NOP_INST and out_pc = 0 whenever state is EMPTY, including after flush.
REQ-025 SHALL give a latency of 1 cycle from accept in EMPTY to out_valid = 1.
REQ-026 SHALL sustain full throughput: with out_ready held at 1, one entry per cycle and no bubbles.
REQ-027 SHALL preserve order; no entry is duplicated or dropped except by flush.
REQ-028 SHALL increment bp_cnt by 1 each cycle with out_valid & !out_ready; it saturates at 2^CNT_W-1 and does not wrap. flush SHALL NOT clear it.
REQ-029 SHALL never assert in_ready and out_valid combinationally from in_valid/out_ready; no combinational path from input to output.

Reset
REQ-030 SHALL, with nrst = 0 at a rising edge, force: state EMPTY, out_valid 0, in_ready 1, out_pc 0, out_inst NOP_INST, skid cleared, bp_cnt 0.
REQ-031 SHALL give nrst priority over flush and all handshakes; reset mid-transfer SHALL drop both entries.

Verification
REQ-032 SHALL be verified by this scenario: reset, then in_valid=1, pc=0x100, inst=0x00500093, out_ready=1 -> next cycle out_valid=1, out_pc=0x100, out_inst=0x00500093.
REQ-033 SHALL be verified by this scenario: stream pc 0x0,0x4,0x8,0xC with out_ready=1 -> four consecutive outputs in order, in_ready stays 1, bp_cnt=0.
REQ-034 SHALL be verified by this scenario: out_ready=0 while feeding 0x20,0x24,0x28 -> state FULL after 2 accepts, in_ready=0, 0x28 held upstream. Then out_ready=1 -> outputs 0x20,0x24,0x28 in order. bp_cnt equals stalled cycles.
REQ-035 SHALL be verified by this scenario: FULL with 0x40/0x44, flush=1 with in_valid=1 pc=0x48 -> next cycle out_valid=0, out_inst=0x00000013, out_pc=0, in_ready=1, 0x48 never appears.
REQ-036 SHALL be verified by this scenario: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> bp_cnt=15 and holds.
REQ-037 SHALL be verified by this scenario: nrst=0 asserted while FULL -> next cycle all outputs at REQ-030 values.
